signed_digit_decompose_pipe: RTL and testbench

//  Streaming, pipelined signed-digit (gadget) decomposer for FHEW accumulator/key-switch paths.

---
 rtl/signed_digit_decompose_pipe_pkg.sv | 12 +
 rtl/signed_digit_decompose_pipe_digit_stage.sv | 57 +++++
 rtl/signed_digit_decompose_pipe.sv | 150 +++++++++++++++
 tb/tb_signed_digit_decompose_pipe.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/signed_digit_decompose_pipe_pkg.sv
// Shared defaults for the signed-digit (gadget) decomposer.
// Contents: coefficient width, modulus, digit base, digit count and ring size
// used as parameter defaults by the pipeline and its digit stages.
package signed_digit_decompose_pipe_pkg;

    localparam int          SDD_DATA_W     = 27;
    localparam logic [26:0] SDD_Q          = 27'h7FFF801;
    localparam int          SDD_LOG_B      = 7;
    localparam int          SDD_NUM_DIGITS = 4;
    localparam int          SDD_RING_N     = 512;

endpackage

// File: rtl/signed_digit_decompose_pipe_digit_stage.sv
// One registered digit-extraction stage of the signed-digit decomposer.
// Takes a signed remainder, peels off the balanced low digit in [-B/2, B/2)
// and passes on the exactly-divided remainder.
// Ports:
//   clk, rstn  clock / async active-low reset (valid only)
//   en         pipeline advance; the stage holds when low
//   vld_in     remainder present
//   r_in       signed remainder, DATA_W+1 bits
//   vld_out    registered valid
//   d_out      registered balanced digit, signed LOG_B bits
//   r_out      registered (r_in - d) >>> LOG_B
module sdd_digit_stage
    import signed_digit_decompose_pipe_pkg::*;
#(
    parameter int DATA_W = SDD_DATA_W,
    parameter int LOG_B  = SDD_LOG_B
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     en,
    input  logic                     vld_in,
    input  logic signed [DATA_W:0]   r_in,
    output logic                     vld_out,
    output logic signed [LOG_B-1:0]  d_out,
    output logic signed [DATA_W:0]   r_out
);

    logic signed [LOG_B-1:0] d_c;
    logic signed [DATA_W:0]  d_ext;
    logic signed [DATA_W:0]  diff;
    logic signed [DATA_W:0]  r_next;

    // Reading the low LOG_B bits as two's complement is exactly
    // t >= B/2 ? t - B : t, so no compare is needed.
    always_comb begin
        d_c    = r_in[LOG_B-1:0];
        d_ext  = {{(DATA_W+1-LOG_B){d_c[LOG_B-1]}}, d_c};
        diff   = r_in - d_ext;
        r_next = diff >>> LOG_B;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_out <= 1'b0;
        end else if (en) begin
            vld_out <= vld_in;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            d_out <= d_c;
            r_out <= r_next;
        end
    end

endmodule

// File: rtl/signed_digit_decompose_pipe.sv
// Streaming signed-digit (gadget) decomposer.
// Each accepted coefficient a in [0,Q) is centred to (-Q/2, Q/2] and split into
// NUM_DIGITS balanced base-2^LOG_B digits, each emitted as a mod-Q residue
// (negative d -> Q+d). Latency NUM_DIGITS+1, throughput one per cycle.
// Ports:
//   clk, rstn             clock / async active-low reset
//   in_valid/in_ready     input handshake, in_data = coefficient
//   out_valid/out_ready   output handshake
//   out_digits            digit i at [i*DATA_W +: DATA_W], i=0 least significant
//   out_last              current output is coefficient RING_N-1 of a polynomial
//   out_index             coefficient index of current output
//   range_err             sticky: some accepted in_data was >= Q
module signed_digit_decompose_pipe
    import signed_digit_decompose_pipe_pkg::*;
#(
    parameter int                DATA_W     = SDD_DATA_W,
    parameter logic [DATA_W-1:0] Q          = DATA_W'(SDD_Q),
    parameter int                LOG_B      = SDD_LOG_B,
    parameter int                NUM_DIGITS = SDD_NUM_DIGITS,
    parameter int                RING_N     = SDD_RING_N
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [DATA_W-1:0]              in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_DIGITS*DATA_W-1:0]   out_digits,
    output logic                           out_last,
    output logic [$clog2(RING_N)-1:0]      out_index,
    output logic                           range_err
);

    localparam int                IDX_W  = $clog2(RING_N);
    localparam int                ND     = NUM_DIGITS;
    localparam logic [DATA_W:0]   HALF_Q = ({1'b0, Q} + 1'b1) >> 1;
    localparam logic [IDX_W-1:0]  LAST_I = IDX_W'(RING_N - 1);

    function automatic logic signed [DATA_W:0] centre(input logic [DATA_W-1:0] a);
        if ({1'b0, a} >= HALF_Q) return $signed({1'b0, a} - {1'b0, Q});
        else                     return $signed({1'b0, a});
    endfunction

    // Q+d always lands in [0,Q), so the low DATA_W bits of the wrapped sum
    // are the residue.
    function automatic logic [DATA_W-1:0] to_residue(input logic signed [DATA_W:0] d);
        return d[DATA_W-1:0] + (d[DATA_W] ? Q : '0);
    endfunction

    function automatic logic signed [DATA_W:0] sext(input logic [LOG_B-1:0] v);
        return {{(DATA_W+1-LOG_B){v[LOG_B-1]}}, v};
    endfunction

    logic                          adv;
    logic                          accept;
    logic [IDX_W-1:0]              cnt;

    logic                          vld_p0;
    logic signed [DATA_W:0]        r_p0;
    logic [IDX_W-1:0]              idx_p [0:ND-1];

    logic                          vld_s [1:ND-1];
    logic signed [DATA_W:0]        r_s   [1:ND-1];
    logic signed [LOG_B-1:0]       d_s   [1:ND-1];

    // dv_p[k]: digits 0..k-2 delayed alongside stage k; dv_m[k] adds digit k-1.
    logic [ND-2:0][LOG_B-1:0]      dv_p  [1:ND-1];
    logic [ND-2:0][LOG_B-1:0]      dv_m  [1:ND-1];
    logic [ND*DATA_W-1:0]          digits_c;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign accept   = in_valid && adv;

    // ---- S0: centring, index tag, range check ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_p0    <= 1'b0;
            cnt       <= '0;
            range_err <= 1'b0;
        end else begin
            if (adv) vld_p0 <= in_valid;
            if (accept) begin
                cnt <= (cnt == LAST_I) ? '0 : cnt + 1'b1;
                if (in_data >= Q) range_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            r_p0     <= centre(in_data);
            idx_p[0] <= cnt;
            for (int k = 1; k < ND; k++) idx_p[k] <= idx_p[k-1];
            dv_p[1]  <= '0;
            for (int k = 2; k < ND; k++) dv_p[k] <= dv_m[k-1];
        end
    end

    // ---- S1..S(ND-1): one digit per stage ----
    for (genvar i = 1; i < ND; i++) begin : g_stage
        if (i == 1) begin : g_first
            sdd_digit_stage #(.DATA_W(DATA_W), .LOG_B(LOG_B)) u_stage (
                .clk(clk), .rstn(rstn), .en(adv),
                .vld_in(vld_p0), .r_in(r_p0),
                .vld_out(vld_s[i]), .d_out(d_s[i]), .r_out(r_s[i])
            );
        end else begin : g_next
            sdd_digit_stage #(.DATA_W(DATA_W), .LOG_B(LOG_B)) u_stage (
                .clk(clk), .rstn(rstn), .en(adv),
                .vld_in(vld_s[i-1]), .r_in(r_s[i-1]),
                .vld_out(vld_s[i]), .d_out(d_s[i]), .r_out(r_s[i])
            );
        end
    end

    always_comb begin
        for (int k = 1; k < ND; k++) begin
            dv_m[k]      = dv_p[k];
            dv_m[k][k-1] = d_s[k];
        end
    end

    // The last digit takes the whole remaining remainder, absorbing any carry.
    always_comb begin
        digits_c = '0;
        for (int j = 0; j < ND-1; j++)
            digits_c[j*DATA_W +: DATA_W] = to_residue(sext(dv_m[ND-1][j]));
        digits_c[(ND-1)*DATA_W +: DATA_W] = to_residue(r_s[ND-1]);
    end

    // ---- S(ND): residue encoding and output register ----
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_index  <= '0;
            out_digits <= '0;
        end else if (adv) begin
            out_valid <= vld_s[ND-1];
            if (vld_s[ND-1]) begin
                out_digits <= digits_c;
                out_index  <= idx_p[ND-1];
                out_last   <= (idx_p[ND-1] == LAST_I);
            end
        end
    end

endmodule

// File: tb/tb_signed_digit_decompose_pipe.sv
module tb_signed_digit_decompose_pipe;

    localparam int     DW = 27;
    localparam int     LB = 7;
    localparam int     ND = 4;
    localparam int     RN = 512;
    localparam int     VW = ND * DW;
    localparam longint QL = 64'h7FFF801;
    localparam longint BL = 64'd1 << LB;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [VW-1:0] out_digits;
    logic          out_last;
    logic [8:0]    out_index;
    logic          range_err;

    signed_digit_decompose_pipe #(
        .DATA_W(DW), .Q(27'h7FFF801), .LOG_B(LB), .NUM_DIGITS(ND), .RING_N(RN)
    ) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_digits(out_digits),
        .out_last(out_last), .out_index(out_index), .range_err(range_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: centre, then repeatedly take the balanced remainder mod B.
    function automatic longint centred(input longint a);
        return (a >= (QL + 1) / 2) ? a - QL : a;
    endfunction

    function automatic logic [VW-1:0] model_digits(input longint a);
        longint r, d;
        logic [VW-1:0] v;
        r = centred(a);
        v = '0;
        for (int i = 0; i < ND; i++) begin
            if (i < ND - 1) begin
                d = ((r % BL) + BL) % BL;
                if (d >= BL / 2) d = d - BL;
                r = (r - d) / BL;
            end else begin
                d = r;
            end
            v[i*DW +: DW] = (d < 0) ? DW'(QL + d) : DW'(d);
        end
        return v;
    endfunction

    function automatic longint identity_sum(input logic [VW-1:0] v);
        longint s, p, d;
        s = 0;
        p = 1;
        for (int i = 0; i < ND; i++) begin
            d = longint'(v[i*DW +: DW]);
            if (d > QL / 2) d = d - QL;
            s = s + d * p;
            p = p * BL;
        end
        return s;
    endfunction

    function automatic logic [VW-1:0] mkvec(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                            input logic [DW-1:0] d2, input logic [DW-1:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    typedef struct {
        logic [VW-1:0] dig;
        int            idx;
        longint        r0;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   tb_idx = 0;
    int   acc_cyc = 0;
    int   n_out = 0, n_lastseen = 0, first_cyc = 0, last_cyc = 0;

    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            if (q.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                e = q.pop_front();
                check("digits", out_digits, e.dig);
                check("index", out_index, e.idx);
                check("last", out_last, (e.idx == RN - 1));
                check("identity", identity_sum(out_digits), e.r0);
            end
            if (n_out == 0) first_cyc = cyc;
            last_cyc = cyc;
            n_out++;
            if (out_last) n_lastseen++;
        end
    end

    task automatic send(input logic [DW-1:0] a);
        logic acc, ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = a;
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            q.push_back('{model_digits(longint'(a)), tb_idx, centred(longint'(a))});
            tb_idx  = (tb_idx + 1) % RN;
            acc_cyc = cyc;
        end else begin
            check("send_timeout", 0, 1);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (out_valid) begin
                lat = cyc - acc_cyc + 1;
                return;
            end
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 3000; n++) begin
            if (q.size() == 0 && !out_valid) break;
            @(negedge clk);
        end
        check("drain_empty", q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_range_err", range_err, 0);
        check("rst_out_index", out_index, 0);
        repeat (2) @(posedge clk);
        q.delete();
        tb_idx = 0;
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input logic [DW-1:0] a, input logic [VW-1:0] expv, input string tag);
        int lat;
        send(a);
        wait_valid(lat);
        check({tag, "_latency"}, lat, 5);
        check({tag, "_digits"}, out_digits, expv);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #(500_000);
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic done;
        #2;
        do_reset();
        check("reset_out_digits", out_digits, 0);
        check("reset_out_last", out_last, 0);
        check("reset_in_ready", in_ready, 1);

        directed(27'd0,          mkvec(0, 0, 0, 0),            "in_zero");
        directed(27'd1,          mkvec(1, 0, 0, 0),            "in_one");
        directed(27'h7FFF800,    mkvec(27'h7FFF800, 0, 0, 0),  "in_qm1");
        directed(27'd64,         mkvec(27'h7FFF7C1, 1, 0, 0),  "in_64");
        directed(27'd63,         mkvec(27'd63, 0, 0, 0),       "in_63");
        directed(27'h3FFFC00,    model_digits(64'h3FFFC00),    "in_half_lo");
        directed(27'h3FFFC01,    model_digits(64'h3FFFC01),    "in_half_hi");
        drain();

        // Back-to-back polynomial: index restarts at 0 after reset.
        do_reset();
        n_out = 0;
        n_lastseen = 0;
        for (int i = 0; i < RN; i++) send(DW'($urandom_range(32'h7FFF800, 0)));
        drain();
        check("b2b_count", n_out, RN);
        check("b2b_throughput", last_cyc - first_cyc, RN - 1);
        check("b2b_nlast", n_lastseen, 1);
        check("b2b_range_err", range_err, 0);

        // Stall with a full pipe.
        fork
            begin
                for (int i = 0; i < 12; i++) send(DW'($urandom_range(32'h7FFF800, 0)));
            end
            begin
                logic [VW-1:0] held;
                for (int n = 0; n < 100; n++) begin
                    @(negedge clk);
                    if (out_valid) break;
                end
                @(posedge clk);
                #1;
                out_ready = 1'b0;
                held = out_digits;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    check("stall_in_ready", in_ready, 0);
                    check("stall_out_valid", out_valid, 1);
                    check("stall_out_digits", out_digits, held);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Random gaps and random backpressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 150; i++) begin
                    repeat ($urandom_range(2, 0)) begin
                        @(posedge clk);
                        #1;
                    end
                    send(DW'($urandom_range(32'h7FFF800, 0)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(3, 0) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Out-of-range input sets the sticky flag.
        check("range_err_before", range_err, 0);
        send(27'h7FFF801);
        check("range_err_rise", range_err, 1);
        send(27'd5);
        send(27'h7FFFFFF);
        drain();
        check("range_err_sticky", range_err, 1);

        // Reset in the middle of a stream.
        for (int i = 0; i < 6; i++) send(DW'($urandom_range(32'h7FFF800, 0)));
        check("midrst_pre_valid", out_valid, 1);
        do_reset();
        send(27'd1);
        wait_valid(lat);
        check("post_rst_index", out_index, 0);
        check("post_rst_latency", lat, 5);
        drain();

        check("final_queue", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
